hr_calc: RTL

HR_CALC -- requirements
Module: hr_calc

---
 rtl/hr_calc.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hr_calc.sv
// rtl/hr_calc.sv - heart-rate calculator: RR history average, serial divider, rhythm flags
module hr_calc #(
  parameter int CTR_WIDTH = 22,
  parameter int FS_HZ     = 360,
  parameter int HR_WIDTH  = 9,
  parameter int NAVG      = 8,
  parameter int TACHY_BPM = 100,
  parameter int BRADY_BPM = 60
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_ce,
  input  logic [CTR_WIDTH-1:0] i_rr_period,
  input  logic                 i_rr_period_updated,
  output logic [HR_WIDTH-1:0]  o_hr_bpm,
  output logic                 o_hr_valid,
  output logic [CTR_WIDTH-1:0] o_rr_avg,
  output logic                 o_rr_avg_valid,
  output logic                 o_tachy,
  output logic                 o_brady,
  output logic                 o_rr_irregular,
  output logic                 o_busy,
  output logic                 o_rr_dropped
);

  localparam int LOG2N = $clog2(NAVG);
  localparam int SUMW  = CTR_WIDTH + LOG2N;
  localparam int CNTW  = $clog2(NAVG + 1);
  localparam int STPW  = $clog2(CTR_WIDTH + 1);

  localparam logic [CTR_WIDTH-1:0] DIVIDEND  = CTR_WIDTH'(60 * FS_HZ);
  localparam logic [CTR_WIDTH-1:0] HR_MAX    = CTR_WIDTH'((1 << HR_WIDTH) - 1);
  localparam logic [CNTW-1:0]      CNT_FULL  = CNTW'(NAVG);
  localparam logic [STPW-1:0]      LAST_STEP = STPW'(CTR_WIDTH - 1);
  localparam logic [HR_WIDTH-1:0]  TACHY_TH  = HR_WIDTH'(TACHY_BPM);
  localparam logic [HR_WIDTH-1:0]  BRADY_TH  = HR_WIDTH'(BRADY_BPM);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t               state_q;
  logic [CTR_WIDTH-1:0] rr_q;
  logic [CTR_WIDTH-1:0] hist_q [NAVG];
  logic [LOG2N-1:0]     wr_ptr_q;
  logic [SUMW-1:0]      sum_q;
  logic [CNTW-1:0]      cnt_q;
  logic [CTR_WIDTH-1:0] rem_q;
  logic [CTR_WIDTH-1:0] quo_q;
  logic [STPW-1:0]      step_q;

  logic                 accept;
  logic [SUMW-1:0]      sum_d;
  logic [CNTW-1:0]      cnt_d;
  logic [CTR_WIDTH-1:0] avg_d;
  logic [CTR_WIDTH-1:0] diff;
  logic                 irr_d;
  logic [CTR_WIDTH:0]   shifted;
  logic [CTR_WIDTH-1:0] rem_d;
  logic [CTR_WIDTH-1:0] quo_d;
  logic [HR_WIDTH-1:0]  hr_d;

  assign accept = (state_q == IDLE) && i_rr_period_updated && (i_rr_period != '0);
  assign o_busy = (state_q != IDLE);

  // Next-state datapath: running sum/average, irregularity test and one restoring-division step
  always_comb begin
    sum_d = sum_q + {{LOG2N{1'b0}}, rr_q} - {{LOG2N{1'b0}}, hist_q[wr_ptr_q]};
    cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
    avg_d = sum_d[SUMW-1:LOG2N];
    diff  = (rr_q >= o_rr_avg) ? (rr_q - o_rr_avg) : (o_rr_avg - rr_q);
    irr_d = o_rr_avg_valid && (diff > (o_rr_avg >> 2));
    shifted = {rem_q, quo_q[CTR_WIDTH-1]};
    if (shifted >= {1'b0, rr_q}) begin
      rem_d = CTR_WIDTH'(shifted - {1'b0, rr_q});
      quo_d = {quo_q[CTR_WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[CTR_WIDTH-1:0];
      quo_d = {quo_q[CTR_WIDTH-2:0], 1'b0};
    end
    hr_d = (quo_q > HR_MAX) ? HR_WIDTH'(HR_MAX) : quo_q[HR_WIDTH-1:0];
  end

  // Control FSM with registered outputs; everything holds while i_ce is low
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      for (int i = 0; i < NAVG; i++) hist_q[i] <= '0;
      wr_ptr_q       <= '0;
      sum_q          <= '0;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      step_q         <= '0;
      o_hr_bpm       <= '0;
      o_hr_valid     <= 1'b0;
      o_rr_avg       <= '0;
      o_rr_avg_valid <= 1'b0;
      o_tachy        <= 1'b0;
      o_brady        <= 1'b0;
      o_rr_irregular <= 1'b0;
      o_rr_dropped   <= 1'b0;
    end else if (i_ce) begin
      o_hr_valid   <= 1'b0;
      o_rr_dropped <= i_rr_period_updated && !accept;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rr_q    <= i_rr_period;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          // Irregularity uses the average as it stood before this sample
          o_rr_irregular   <= irr_d;
          hist_q[wr_ptr_q] <= rr_q;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
          sum_q            <= sum_d;
          cnt_q            <= cnt_d;
          o_rr_avg_valid   <= (cnt_d == CNT_FULL);
          o_rr_avg         <= (cnt_d == CNT_FULL) ? avg_d : '0;
          rem_q            <= '0;
          quo_q            <= DIVIDEND;
          step_q           <= '0;
          state_q          <= DIVIDE;
        end
        DIVIDE: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          step_q <= step_q + 1'b1;
          if (step_q == LAST_STEP) state_q <= DONE;
        end
        DONE: begin
          o_hr_bpm   <= hr_d;
          o_hr_valid <= 1'b1;
          o_tachy    <= (hr_d > TACHY_TH);
          o_brady    <= (hr_d < BRADY_TH);
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
